hazard_scoreboard: RTL
======================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised successor to the single-cycle load-use detector: a per-register
//  scoreboard that tracks multi-cycle producers (loads, mul/div) in the RV32 pipeline.
//  Sits at ID; stalls IF/ID and bubbles ID/EX while a used source or the destination
//  is still pending. Also keeps a saturating stall-cycle performance counter.
// PARAMETERS
//  REG_AW     5   register address width; NUM_REGS = 2**REG_AW
//  LOAD_LAT   1   stall cycles a load imposes on an immediate dependent (1 = classic 5-stage)
//  MUL_LAT    3   stall cycles a mul/div imposes on an immediate dependent
//  CNT_W      2   busy-counter width; must hold max(LOAD_LAT,MUL_LAT)
//  PERF_W     32  stall-cycle counter width
// PORTS
//  clk_i         in   1       core clock
//  rst_n_i       in   1       asynchronous active-low reset
//  id_valid_i    in   1       ID holds a real instruction
//  rs1_i         in   REG_AW  source 1 index
//  rs2_i         in   REG_AW  source 2 index
//  rs1_used_i    in   1       instruction reads rs1
//  rs2_used_i    in   1       instruction reads rs2
//  rd_i          in   REG_AW  destination index
//  rd_we_i       in   1       instruction writes rd
//  op_class_i    in   2       00 ALU, 01 LOAD, 10 MUL/DIV, 11 reserved (treated as ALU)
//  flush_i       in   1       kill instruction in ID this cycle (branch/jump redirect)
//  stall_en_o    out  1       hold PC and IF/ID, insert bubble into ID/EX
//  raw_hit_o     out  2       {rs2,rs1} RAW hazard contributing to stall
//  waw_hit_o     out  1       WAW hazard contributing to stall
//  stall_cnt_o   out  PERF_W  saturating count of cycles with stall_en_o=1
// BEHAVIOUR
//  - State: busy[r] (CNT_W bits) per register r; busy[0] tied to 0, never written.
//  - lat(op): ALU=0, LOAD=LOAD_LAT, MUL=MUL_LAT, reserved=0.
//  - Combinational, same cycle:
//    raw_hit_o[0] = id_valid_i & rs1_used_i & rs1_i!=0 & busy[rs1_i]!=0; same for [1]/rs2.
//    waw_hit_o = id_valid_i & rd_we_i & rd_i!=0 & busy[rd_i] > lat(op_class_i).
//    stall_en_o = (|raw_hit_o | waw_hit_o) & ~flush_i.
//  - issue = id_valid_i & ~stall_en_o & ~flush_i.
//  - Each clk edge, for every r: if issue & rd_we_i & rd_i==r & r!=0 -> busy[r]=lat(op);
//    else if busy[r]!=0 -> busy[r]-1; else hold. Issue overrides decrement.
//  - Latency: producer issues cycle t -> dependent in ID at t+1 stalls exactly lat cycles,
//    issues at t+1+lat. ALU producers never stall (forwarding assumed).
//  - flush_i: only cancels the ID instruction (no busy load, no stall). Already-issued
//    producers are older than the redirect and keep counting down.
//  - stall_cnt_o: +1 on every cycle stall_en_o=1; holds at all-ones (no wrap).
//  - Reset (async, rst_n_i=0): all busy=0, stall_cnt_o=0; hence stall_en_o=0,
//    raw_hit_o=0, waw_hit_o=0. Reset mid-stall drops stall immediately (async).
//  - Both sources equal and busy: single stall, both raw_hit_o bits set.
//  - Dependent reading its own rd (e.g. lw x5,0(x5)): rs1 checked against pre-issue state.
//  - id_valid_i=0: no hazards reported, no issue; counters still decrement.
// TESTING
//  1 lw x5 ; add x6,x5,x1 (LOAD_LAT=1) -> stall_en_o=1 one cycle, raw_hit_o=01, add issues t+2.
//  2 mul x7 ; sub x8,x1,x7 (MUL_LAT=3) -> stall 3 cycles, raw_hit_o=10, stall_cnt_o +3.
//  3 mul x7 ; addi x7,x0,1 -> waw_hit_o=1 until busy[x7]=0 (3 cycles); lw x7 waits 2.
//  4 lw x0 ; add x1,x0,x0 -> no stall; busy[0] stays 0.
//  5 lw x5 ; dependent with flush_i=1 in same ID cycle -> stall_en_o=0, no busy load.
//  6 rst_n_i low during a MUL stall -> all outputs 0 immediately; after release no stall.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Purpose:
//   Per-register busy scoreboard for the RV32 pipeline, sitting at ID. Each
//   architectural register carries a small down-counter that says how many
//   more cycles a multi-cycle producer (load, mul/div) needs before its
//   result can be forwarded. An instruction in ID that reads a busy source,
//   or that would overwrite a register whose pending producer would finish
//   after it, stalls IF/ID and bubbles ID/EX. ALU producers never stall
//   because their results are covered by forwarding. A saturating counter
//   records how many cycles the pipeline spent stalled.
//
// Ports:
//   clk_i        core clock
//   rst_n_i      asynchronous active-low reset
//   id_valid_i   ID holds a real instruction
//   rs1_i        source 1 register index
//   rs2_i        source 2 register index
//   rs1_used_i   instruction reads rs1
//   rs2_used_i   instruction reads rs2
//   rd_i         destination register index
//   rd_we_i      instruction writes rd
//   op_class_i   00 ALU, 01 LOAD, 10 MUL/DIV, 11 reserved (behaves as ALU)
//   flush_i      kill the ID instruction this cycle (redirect)
//   stall_en_o   hold PC and IF/ID, insert bubble into ID/EX
//   raw_hit_o    {rs2,rs1} read-after-write hazard flags
//   waw_hit_o    write-after-write hazard flag
//   stall_cnt_o  saturating count of stalled cycles
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 3,
  parameter int CNT_W    = 2,
  parameter int PERF_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic              rs1_used_i,
  input  logic              rs2_used_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              rd_we_i,
  input  logic [1:0]        op_class_i,
  input  logic              flush_i,
  output logic              stall_en_o,
  output logic [1:0]        raw_hit_o,
  output logic              waw_hit_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  localparam int NUM_REGS = 2 ** REG_AW;

  typedef enum logic [1:0] {
    OpAlu  = 2'b00,
    OpLoad = 2'b01,
    OpMul  = 2'b10,
    OpRsvd = 2'b11
  } opClass_e;

  opClass_e            opClass;
  logic [CNT_W-1:0]    issueLat;
  logic [CNT_W-1:0]    rs1Busy;
  logic [CNT_W-1:0]    rs2Busy;
  logic [CNT_W-1:0]    rdBusy;
  logic [1:0]          rawHit;
  logic                wawHit;
  logic                stallEn;
  logic                issue;

  logic [CNT_W-1:0]    busy_q [NUM_REGS];
  logic [CNT_W-1:0]    busy_d [NUM_REGS];
  logic [PERF_W-1:0]   stallCnt_q;
  logic [PERF_W-1:0]   stallCnt_d;

  // Number of cycles an immediately following dependent must wait on a
  // producer of the given class. Reserved encodings behave like ALU ops so
  // that an undecoded slot can never wedge the pipeline.
  function automatic logic [CNT_W-1:0] latOf(input opClass_e op);
    logic [CNT_W-1:0] lat;
    lat = '0;
    case (op)
      OpLoad:  lat = CNT_W'(LOAD_LAT);
      OpMul:   lat = CNT_W'(MUL_LAT);
      OpAlu:   lat = '0;
      OpRsvd:  lat = '0;
      default: lat = '0;
    endcase
    return lat;
  endfunction

  assign opClass  = opClass_e'(op_class_i);
  assign issueLat = latOf(opClass);

  // Scoreboard lookups for the instruction currently in ID. Entry 0 is held
  // at zero by the update logic, so x0 can never look busy; the explicit
  // index checks below keep that guarantee even if entry 0 were disturbed.
  assign rs1Busy = busy_q[rs1_i];
  assign rs2Busy = busy_q[rs2_i];
  assign rdBusy  = busy_q[rd_i];

  // Hazard detection. A RAW hit means a used source is still in flight. A
  // WAW hit means the older producer of rd would complete after this one,
  // so letting this instruction go would let the stale result win. The hit
  // flags report the raw conditions; only the stall itself is gated by a
  // flush, since a killed instruction has nothing to wait for.
  always_comb begin
    rawHit[0] = id_valid_i & rs1_used_i & (rs1_i != '0) & (rs1Busy != '0);
    rawHit[1] = id_valid_i & rs2_used_i & (rs2_i != '0) & (rs2Busy != '0);
    wawHit    = id_valid_i & rd_we_i & (rd_i != '0) & (rdBusy > issueLat);
    stallEn   = ((|rawHit) | wawHit) & ~flush_i;
    issue     = id_valid_i & ~stallEn & ~flush_i;
  end

  assign raw_hit_o  = rawHit;
  assign waw_hit_o  = wawHit;
  assign stall_en_o = stallEn;

  // Next-state for every busy counter. A newly issuing producer loads its
  // latency and takes priority over the countdown; every other in-flight
  // entry ticks down by one per cycle whether or not ID is stalled, so
  // older producers keep draining while the pipeline waits. The dependent
  // reading its own destination sees the pre-issue value because the load
  // only lands at the clock edge.
  always_comb begin
    busy_d[0] = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (issue && rd_we_i && (rd_i == REG_AW'(r))) begin
        busy_d[r] = issueLat;
      end else if (busy_q[r] != '0) begin
        busy_d[r] = busy_q[r] - 1'b1;
      end else begin
        busy_d[r] = busy_q[r];
      end
    end
  end

  // Stall-cycle performance counter. It sticks at all-ones rather than
  // wrapping so a long run never reports a misleadingly small figure.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (stallEn && (stallCnt_q != {PERF_W{1'b1}})) begin
      stallCnt_d = stallCnt_q + 1'b1;
    end
  end

  // State registers. Reset is asynchronous so a reset arriving in the middle
  // of a long mul/div stall releases the pipeline without waiting for an
  // edge: all counters clear, which forces every hazard output low.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        busy_q[r] <= '0;
      end
      stallCnt_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        busy_q[r] <= busy_d[r];
      end
      stallCnt_q <= stallCnt_d;
    end
  end

  assign stall_cnt_o = stallCnt_q;

endmodule
